// File: rtl/stopwatch_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stopwatch_counter_pkg                                           |
// | Purpose  : Shared stopwatch types and time-base constants                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package stopwatch_counter_pkg;

    localparam int TIME_CNT_W   = 39;
    localparam int TICKS_PER_MS = 100000;
    // 60 min * 60 s * 1000 ms * 100000 ticks/ms - 1, i.e. 59:59.999
    localparam logic [TIME_CNT_W-1:0] MAX_TIME_TICKS = 39'd359_999_999_999;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_PAUSED    = 2'd2,
        ST_SATURATED = 2'd3
    } sw_state_e;

endpackage
`default_nettype wire

// File: rtl/stopwatch_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stopwatch_counter_if                                            |
// | Purpose  : Button inputs and time/status outputs of the stopwatch          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface stopwatch_counter_if
    import stopwatch_counter_pkg::*;
#(
    parameter int CNT_W = TIME_CNT_W
);
    logic             btn_start;
    logic             btn_clear;
    logic             btn_lap;
    logic [CNT_W-1:0] time_out;
    logic             running;
    logic             overflow;
    logic             lap_active;

    modport master (
        output btn_start, btn_clear, btn_lap,
        input  time_out, running, overflow, lap_active
    );

    modport slave (
        input  btn_start, btn_clear, btn_lap,
        output time_out, running, overflow, lap_active
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_counter_btn_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : btn_edge_sync                                                   |
// | Purpose  : 2-flop synchronizer plus registered one-cycle rising-edge pulse |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module btn_edge_sync (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  btn,
    output logic pulse
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= r_sync2 & ~r_prev;
        end
    end

    assign pulse = r_pulse;
endmodule
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stopwatch_counter                                               |
// | Purpose  : Start/stop/clear tick counter saturating at MAX_COUNT.          |
// |            Lap hold is built only with STOPWATCH_LAP_HOLD_EN defined.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int               CNT_W     = TIME_CNT_W,
    parameter logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_TIME_TICKS),
    parameter int               TICK_DIV  = 1
) (
    input wire                  clk,
    input wire                  rst_n,
    stopwatch_counter_if.slave  bus
);
    sw_state_e        r_state;
    sw_state_e        w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] r_time_out;
    logic [CNT_W-1:0] w_time_next;
    logic             w_tick;
    logic             w_cmd_start;
    logic             w_cmd_clear;

    btn_edge_sync u_start_sync (.clk(clk), .rst_n(rst_n), .btn(bus.btn_start), .pulse(w_cmd_start));
    btn_edge_sync u_clear_sync (.clk(clk), .rst_n(rst_n), .btn(bus.btn_clear), .pulse(w_cmd_clear));

    if (TICK_DIV > 1) begin : g_prescale
        localparam int c_pre_w = $clog2(TICK_DIV);
        logic [c_pre_w-1:0] r_pre;
        logic               w_enter_run;
        logic               w_pre_last;

        assign w_enter_run = (w_state_next == ST_RUNNING) && (r_state != ST_RUNNING);
        assign w_pre_last  = (r_pre == c_pre_w'(TICK_DIV - 1));
        assign w_tick      = (r_state == ST_RUNNING) && w_pre_last;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pre <= '0;
            end else if (w_enter_run) begin
                r_pre <= '0;
            end else if (r_state == ST_RUNNING) begin
                r_pre <= w_pre_last ? '0 : r_pre + 1'b1;
            end
        end
    end else begin : g_no_prescale
        assign w_tick = (r_state == ST_RUNNING);
    end

    // Clear outranks every other command; start outranks a coincident tick.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        if (w_cmd_clear) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_count_next = '0;
                    if (w_cmd_start) w_state_next = ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (w_cmd_start) begin
                        w_state_next = ST_PAUSED;
                    end else if (w_tick) begin
                        if (r_count == MAX_COUNT - 1'b1) begin
                            w_count_next = MAX_COUNT;
                            w_state_next = ST_SATURATED;
                        end else begin
                            w_count_next = r_count + 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (w_cmd_start) w_state_next = ST_RUNNING;
                end
                ST_SATURATED: begin
                    w_count_next = MAX_COUNT;
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end
            endcase
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic             w_cmd_lap;
    logic             r_lap_active;
    logic             w_lap_next;
    logic [CNT_W-1:0] r_lap_reg;
    logic [CNT_W-1:0] w_lap_reg_next;

    btn_edge_sync u_lap_sync (.clk(clk), .rst_n(rst_n), .btn(bus.btn_lap), .pulse(w_cmd_lap));

    always_comb begin
        w_lap_next     = r_lap_active;
        w_lap_reg_next = r_lap_reg;
        if (w_cmd_clear) begin
            w_lap_next = 1'b0;
        end else if (w_state_next == ST_SATURATED && r_state != ST_SATURATED) begin
            w_lap_next = 1'b0;
        end else if (w_cmd_lap && (r_state == ST_RUNNING || r_state == ST_PAUSED)) begin
            if (!r_lap_active) begin
                w_lap_next     = 1'b1;
                w_lap_reg_next = r_count;
            end else begin
                w_lap_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_active <= 1'b0;
            r_lap_reg    <= '0;
        end else begin
            r_lap_active <= w_lap_next;
            r_lap_reg    <= w_lap_reg_next;
        end
    end

    assign w_time_next    = w_lap_next ? w_lap_reg_next : w_count_next;
    assign bus.lap_active = r_lap_active;
`else
    assign w_time_next    = w_count_next;
    assign bus.lap_active = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_time_out <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_time_out <= w_time_next;
        end
    end

    assign bus.time_out = r_time_out;
    assign bus.running  = (r_state == ST_RUNNING);
    assign bus.overflow = (r_state == ST_SATURATED);
endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stopwatch_counter                                            |
// | Purpose  : Scoreboard bench for two stopwatch_counter configurations;      |
// |            lap checks follow STOPWATCH_LAP_HOLD_EN.                        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_stopwatch_counter;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUS = 2;
    localparam int M_SAT  = 3;

    typedef struct {
        longint t;
        bit     run;
        bit     ovf;
        bit     lap;
    } exp_t;

    logic clk = 1'b0;
    bit   clk_en = 1'b0;
    logic rst_n;
    logic btn_s, btn_c, btn_l;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    longint c_max[2] = '{1000, 300};
    longint c_div[2] = '{1, 4};

    int     m_mode[2];
    longint m_cnt[2];
    longint m_runc[2];
    longint m_lapv[2];
    bit     m_lap[2];
    bit [3:0] h_s, h_c, h_l;
    exp_t   q[2][$];

    always #5 clk = clk_en ? ~clk : clk;

    stopwatch_counter_if #(.CNT_W(39)) bus_a ();
    stopwatch_counter_if #(.CNT_W(39)) bus_b ();

    assign bus_a.btn_start = btn_s;
    assign bus_a.btn_clear = btn_c;
    assign bus_a.btn_lap   = btn_l;
    assign bus_b.btn_start = btn_s;
    assign bus_b.btn_clear = btn_c;
    assign bus_b.btn_lap   = btn_l;

    stopwatch_counter #(.CNT_W(39), .MAX_COUNT(39'd1000), .TICK_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    stopwatch_counter #(.CNT_W(39), .MAX_COUNT(39'd300), .TICK_DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_cnt[i] = 0; m_runc[i] = 0;
            m_lapv[i] = 0;      m_lap[i] = 1'b0;
        end
        h_s = '0; h_c = '0; h_l = '0;
    endfunction

    // One clock edge of stopwatch behaviour for configuration i.
    function automatic exp_t step(int i, bit cs, bit cc, bit cl);
        exp_t   e;
        int     om = m_mode[i];
        longint oc = m_cnt[i];
        if (cc) begin
            m_mode[i] = M_IDLE; m_cnt[i] = 0; m_lap[i] = 1'b0;
        end else begin
            case (om)
                M_IDLE, M_PAUS: if (cs) begin m_mode[i] = M_RUN; m_runc[i] = 0; end
                M_RUN: begin
                    if (cs) m_mode[i] = M_PAUS;
                    else begin
                        m_runc[i]++;
                        if (m_runc[i] % c_div[i] == 0) begin
                            if (m_cnt[i] + 1 == c_max[i]) begin
                                m_cnt[i] = c_max[i]; m_mode[i] = M_SAT;
                            end else m_cnt[i]++;
                        end
                    end
                end
                default: ;
            endcase
`ifdef STOPWATCH_LAP_HOLD_EN
            if (m_mode[i] == M_SAT && om != M_SAT) m_lap[i] = 1'b0;
            else if (cl && (om == M_RUN || om == M_PAUS)) begin
                if (!m_lap[i]) begin m_lap[i] = 1'b1; m_lapv[i] = oc; end
                else m_lap[i] = 1'b0;
            end
`else
            if (cl && oc < 0) m_lap[i] = 1'b0;
`endif
        end
        e.t   = m_lap[i] ? m_lapv[i] : m_cnt[i];
        e.run = (m_mode[i] == M_RUN);
        e.ovf = (m_mode[i] == M_SAT);
        e.lap = m_lap[i];
        return e;
    endfunction

    // A level sampled high at edge N after being low at N-1 acts at edge N+3.
    always @(posedge clk) begin
        bit cs, cc, cl;
        if (!rst_n) begin
            model_reset();
            for (int i = 0; i < 2; i++) q[i].push_back('{0, 1'b0, 1'b0, 1'b0});
        end else begin
            cs = h_s[2] & ~h_s[3];
            cc = h_c[2] & ~h_c[3];
            cl = h_l[2] & ~h_l[3];
            h_s = {h_s[2:0], btn_s};
            h_c = {h_c[2:0], btn_c};
            h_l = {h_l[2:0], btn_l};
            for (int i = 0; i < 2; i++) q[i].push_back(step(i, cs, cc, cl));
        end
    end

    always @(negedge clk) begin
        exp_t   e;
        longint t_act;
        bit     r_act, o_act, l_act;
        n_cyc++;
        for (int i = 0; i < 2; i++) begin
            t_act = (i == 0) ? longint'(bus_a.time_out) : longint'(bus_b.time_out);
            r_act = (i == 0) ? bus_a.running    : bus_b.running;
            o_act = (i == 0) ? bus_a.overflow   : bus_b.overflow;
            l_act = (i == 0) ? bus_a.lap_active : bus_b.lap_active;
            n_tests++;
            if (q[i].size() == 0) begin
                n_fail++;
                $display("FAIL dut%0d cyc=%0d no expected entry in scoreboard", i, n_cyc);
            end else begin
                e = q[i].pop_front();
                if (t_act != e.t || r_act != e.run || o_act != e.ovf || l_act != e.lap) begin
                    n_fail++;
                    $display("FAIL dut%0d cyc=%0d actual t=%0d run=%0b ovf=%0b lap=%0b required t=%0d run=%0b ovf=%0b lap=%0b",
                             i, n_cyc, t_act, r_act, o_act, l_act, e.t, e.run, e.ovf, e.lap);
                end
            end
        end
    end

    task automatic chk_zero(string name);
        logic [41:0] act;
        act = {bus_a.time_out[0 +: 1], bus_a.running, bus_a.overflow, bus_a.lap_active,
               bus_b.time_out[0 +: 1], bus_b.running, bus_b.overflow, bus_b.lap_active, 34'd0};
        n_tests++;
        if (bus_a.time_out != '0 || bus_b.time_out != '0 || act != '0) begin
            n_fail++;
            $display("FAIL %s actual a.t=%0d b.t=%0d flags=%b required all zero",
                     name, bus_a.time_out, bus_b.time_out, act[41:34]);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(int which);
        if (which == 0) btn_s = 1'b1; else if (which == 1) btn_c = 1'b1; else btn_l = 1'b1;
        cyc(4);
        if (which == 0) btn_s = 1'b0; else if (which == 1) btn_c = 1'b0; else btn_l = 1'b0;
        cyc(4);
    endtask

    initial begin
        btn_s = 1'b1; btn_c = 1'b0; btn_l = 1'b0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk_zero("reset_no_clock");
        #5 clk_en = 1'b1;
        cyc(3);
        @(negedge clk); #1 rst_n = 1'b1;
        cyc(2); btn_s = 1'b0;
        cyc(600);
        press(0); cyc(200);
        press(0); cyc(300);
        press(1);
        press(0); cyc(1200);
        press(0); cyc(20);
        press(1);
        press(0); cyc(250);
        btn_s = 1'b1; btn_c = 1'b1; cyc(4);
        btn_s = 1'b0; btn_c = 1'b0; cyc(10);
        press(0); cyc(400);
        press(2); cyc(100);
        press(2); cyc(50);
        press(2); cyc(20);
        press(0); press(2); cyc(30);
        press(1);
        press(0); cyc(100);
        @(negedge clk); #1 rst_n = 1'b0;
        #1 chk_zero("reset_midrun");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            cyc(1);
            if ($urandom_range(0, 99) < 3)  btn_s = ~btn_s;
            if ($urandom_range(0, 399) < 1) btn_c = ~btn_c;
            if ($urandom_range(0, 99) < 2)  btn_l = ~btn_l;
        end
        cyc(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
